// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - frame geometry, luma coefficients and FSM state type
// Shared between gray_frame_loader and image_processor.
package img_pkg;

  localparam int IMG_W       = 400;
  localparam int IMG_H       = 300;
  localparam int DATA_LENGTH = IMG_W * IMG_H;

  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;
  localparam int SUM_W  = 14;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/rgb444_to_gray.sv
// rtl/rgb444_to_gray.sv - two-stage RGB444 to replicated-luma pipeline
// Address, odd-row and last-pixel flags travel alongside the data.
module rgb444_to_gray #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19,
  parameter int KEEP_ODD   = 0
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_odd,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);
  import img_pkg::*;

  logic [SUM_W-1:0]      sum;
  logic                  s1_valid;
  logic [SUM_W-1:0]      s1_sum;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_odd;
  logic                  s1_last;
  logic [3:0]            y;

  // +128 rounds the >>8 to nearest
  always_comb begin
    sum = SUM_W'(COEF_R) * SUM_W'(in_data[11:8])
        + SUM_W'(COEF_G) * SUM_W'(in_data[7:4])
        + SUM_W'(COEF_B) * SUM_W'(in_data[3:0])
        + SUM_W'(128);
  end

  // Sum never exceeds 3968, so the clamp can never engage
  always_comb begin
    y = (s1_sum[SUM_W-1:12] != '0) ? 4'hF : s1_sum[11:8];
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_addr   <= '0;
      s1_odd    <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_sum  <= sum;
        s1_addr <= in_addr;
        s1_odd  <= in_odd;
        s1_last <= in_last;
      end
      if (s1_valid) begin
        out_data <= (s1_odd && KEEP_ODD == 0) ? '0 : {y, y, y};
        out_addr <= s1_addr;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: rtl/gray_frame_loader.sv
// rtl/gray_frame_loader.sv - raster RGB444 stream to decimated grey frame in BRAM
// Holds the frame FSM, raster counters and write address; luma math lives in rgb444_to_gray.
module gray_frame_loader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19,
  parameter int IMG_W      = img_pkg::IMG_W,
  parameter int IMG_H      = img_pkg::IMG_H,
  parameter int KEEP_ODD   = 0
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sof,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  hold,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  frame_done,
  output logic                  sync_err
);
  import img_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t                state, state_next;
  logic                  accept, take, last_px;
  logic [COL_W-1:0]      col, pos_col;
  logic [ROW_W-1:0]      row, pos_row;
  logic [ADDR_WIDTH-1:0] addr, pos_addr;
  logic                  p_valid, p_odd, p_last, out_last;
  logic [DATA_WIDTH-1:0] p_data;
  logic [ADDR_WIDTH-1:0] p_addr;

  assign s_ready = !hold;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // An sof pixel always lands at col 0 / row 0 / addr 0, whatever the counters say
  always_comb begin
    state_next = state;
    take       = 1'b0;
    pos_col    = s_sof ? '0 : col;
    pos_row    = s_sof ? '0 : row;
    pos_addr   = s_sof ? '0 : addr;
    last_px    = (pos_col == COL_W'(IMG_W - 1)) && (pos_row == ROW_W'(IMG_H - 1));
    case (state)
      IDLE, DONE: take = accept && s_sof;
      STREAM:     take = accept;
      default:    take = 1'b0;
    endcase
    if (take) state_next = last_px ? DONE : STREAM;
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      p_valid    <= 1'b0;
      p_data     <= '0;
      p_addr     <= '0;
      p_odd      <= 1'b0;
      p_last     <= 1'b0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      p_valid <= take;
      if (take) begin
        p_data <= s_data;
        p_addr <= pos_addr;
        p_odd  <= pos_row[0];
        p_last <= last_px;
        addr   <= last_px ? '0 : pos_addr + 1'b1;
        if (pos_col == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= (pos_row == ROW_W'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
        end else begin
          col <= pos_col + 1'b1;
          row <= pos_row;
        end
      end
      if (accept && s_sof && state == STREAM) sync_err <= 1'b1;
      // Done follows the final write, not the FSM, so it rises after the data is in BRAM
      if (take && s_sof)             frame_done <= 1'b0;
      else if (bram_we && out_last)  frame_done <= 1'b1;
    end
  end

  rgb444_to_gray #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .KEEP_ODD   (KEEP_ODD)
  ) u_luma (
    .clk_p     (clk_p),
    .rst       (rst),
    .in_valid  (p_valid),
    .in_data   (p_data),
    .in_addr   (p_addr),
    .in_odd    (p_odd),
    .in_last   (p_last),
    .out_valid (bram_we),
    .out_data  (bram_wdata),
    .out_addr  (bram_addr),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_gray_frame_loader.sv
// tb/tb_gray_frame_loader.sv - directed bench for gray_frame_loader on an 8x6 frame
// Two instances share stimulus: one zeroing odd rows, one keeping them.
module tb_gray_frame_loader;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk_p, rst, s_valid, s_sof, hold;
  logic [11:0] s_data;
  logic        s_ready, bram_we, frame_done, sync_err;
  logic [18:0] bram_addr;
  logic [11:0] bram_wdata;
  logic        s_ready_k, bram_we_k, frame_done_k, sync_err_k;
  logic [18:0] bram_addr_k;
  logic [11:0] bram_wdata_k;

  int n_cmp = 0;
  int n_bad = 0;

  gray_frame_loader #(.IMG_W(W), .IMG_H(H), .KEEP_ODD(0)) dut (
    .clk_p(clk_p), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .hold(hold), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .frame_done(frame_done), .sync_err(sync_err)
  );

  gray_frame_loader #(.IMG_W(W), .IMG_H(H), .KEEP_ODD(1)) dut_k (
    .clk_p(clk_p), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_k), .s_sof(s_sof),
    .s_data(s_data), .hold(hold), .bram_we(bram_we_k), .bram_addr(bram_addr_k),
    .bram_wdata(bram_wdata_k), .frame_done(frame_done_k), .sync_err(sync_err_k)
  );

  initial clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  // Write monitor: sees the registered BRAM outputs just before each edge updates them
  logic [11:0] mem   [N];
  logic [11:0] mem_k [N];
  int          hits  [N];
  int          hits_k[N];
  int          wr_cnt, wr_cnt_k, order_bad, prev_addr;
  logic        mon_clr;

  always @(posedge clk_p) begin : mon
    int a;
    if (mon_clr) begin
      wr_cnt = 0; wr_cnt_k = 0; order_bad = 0; prev_addr = -1;
      for (int i = 0; i < N; i++) begin
        hits[i] = 0; hits_k[i] = 0; mem[i] = 12'hBAD; mem_k[i] = 12'hBAD;
      end
    end else begin
      if (bram_we) begin
        a = int'(bram_addr);
        wr_cnt++;
        if (a != prev_addr + 1) order_bad++;
        prev_addr = a;
        if (a < N) begin hits[a]++; mem[a] = bram_wdata; end
        else order_bad++;
      end
      if (bram_we_k) begin
        a = int'(bram_addr_k);
        wr_cnt_k++;
        if (a < N) begin hits_k[a]++; mem_k[a] = bram_wdata_k; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one pixel for one cycle; returns at the falling edge after it was taken
  task automatic send(input logic [11:0] d, input logic sof);
    @(negedge clk_p);
    s_valid = 1'b1; s_sof = sof; s_data = d;
    @(negedge clk_p);
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [11:0] d, input logic sof,
                          input logic [18:0] ea, input logic [11:0] ed);
    send(d, sof);
    repeat (2) @(negedge clk_p);
    chk({tag, "_we"}, bram_we, 1);
    chk({tag, "_addr"}, bram_addr, ea);
    chk({tag, "_data"}, bram_wdata, ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, cyc, sent, rdy_bad;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; hold = 1'b0; mon_clr = 1'b1;
    repeat (3) @(negedge clk_p);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_sync", sync_err, 0);
    chk("rst_ready", s_ready, 1);
    hold = 1'b1; #1;
    chk("hold_ready", s_ready, 0);
    hold = 1'b0;
    @(negedge clk_p);
    rst = 1'b0; mon_clr = 1'b0;

    // Pixels before any sof are dropped
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_p);
      s_valid = 1'b1; s_sof = 1'b0; s_data = 12'hFFF;
    end
    @(negedge clk_p);
    s_valid = 1'b0;
    repeat (3) @(negedge clk_p);
    chk("idle_drop", wr_cnt, 0);

    // Latency: write appears two edges after the accepting edge
    send(12'hFFF, 1'b1);
    chk("lat_e0_we", bram_we, 0);
    @(negedge clk_p);
    chk("lat_e1_we", bram_we, 0);
    @(negedge clk_p);
    chk("px_fff_we", bram_we, 1);
    chk("px_fff_addr", bram_addr, 0);
    chk("px_fff_data", bram_wdata, 12'hFFF);
    send_chk("px_f00", 12'hF00, 1'b0, 19'd1, 12'h555);
    send_chk("px_000", 12'h000, 1'b0, 19'd2, 12'h000);
    chk("no_sync_yet", sync_err, 0);

    // sof mid-frame restarts at address 0 and latches sync_err
    send(12'h888, 1'b1);
    chk("sync_set", sync_err, 1);
    repeat (2) @(negedge clk_p);
    chk("resync_addr", bram_addr, 0);
    chk("resync_data", bram_wdata, 12'h888);

    // Reset with pixels in flight flushes the pipeline
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_p);
      s_valid = 1'b1; s_sof = 1'b0; s_data = 12'h888;
    end
    @(negedge clk_p);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk_p);
    chk("midrst_we", bram_we, 0);
    chk("midrst_sync", sync_err, 0);
    rst = 1'b0;
    c = wr_cnt;
    repeat (5) @(negedge clk_p);
    chk("midrst_flush", wr_cnt, c);
    chk("midrst_done", frame_done, 0);

    // Frame A: back-to-back 0x888
    mon_clr = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk_p);
      mon_clr = 1'b0; s_valid = 1'b1; s_sof = (i == 0); s_data = 12'h888;
    end
    @(negedge clk_p);
    s_valid = 1'b0; s_sof = 1'b0;
    chk("fa_done_e0", frame_done, 0);
    @(negedge clk_p);
    chk("fa_done_e1", frame_done, 0);
    @(negedge clk_p);
    chk("fa_last_we", bram_we, 1);
    chk("fa_last_addr", bram_addr, N - 1);
    chk("fa_done_e2", frame_done, 0);
    @(negedge clk_p);
    chk("fa_done_e3", frame_done, 1);
    chk("fa_done_k", frame_done_k, 1);
    @(negedge clk_p);
    chk("fa_cnt", wr_cnt, N);
    chk("fa_cnt_k", wr_cnt_k, N);
    chk("fa_order", order_bad, 0);
    chk("fa_sync", sync_err, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fa_hits[%0d]", i), hits[i], 1);
      chk($sformatf("fa_mem[%0d]", i), mem[i], ((i / W) % 2 == 1) ? 12'h000 : 12'h888);
      chk($sformatf("fa_memk[%0d]", i), mem_k[i], 12'h888);
    end

    // DONE ignores non-sof pixels
    send(12'hFFF, 1'b0);
    repeat (3) @(negedge clk_p);
    chk("done_drop", wr_cnt, N);
    chk("done_hold", frame_done, 1);

    // Frame B: 0x0F0 with random valid gaps and hold toggling every 7 cycles
    mon_clr = 1'b1;
    cyc = 0; sent = 0; rdy_bad = 0;
    while (sent < N && cyc < 3000) begin
      @(negedge clk_p);
      mon_clr = 1'b0;
      hold = ((cyc / 7) % 2) == 1;
      s_valid = ($urandom_range(0, 3) != 0);
      s_sof = (sent == 0);
      s_data = 12'h0F0;
      #1;
      if (s_ready !== !hold || s_ready_k !== !hold) rdy_bad++;
      cyc++;
      @(posedge clk_p);
      if (s_valid && !hold) begin
        if (sent == 0) begin
          #1;
          chk("fb_done_clr", frame_done, 0);
        end
        sent++;
      end
    end
    @(negedge clk_p);
    s_valid = 1'b0; s_sof = 1'b0; hold = 1'b0;
    chk("fb_sent", sent, N);
    chk("fb_ready", rdy_bad, 0);
    repeat (5) @(negedge clk_p);
    chk("fb_done", frame_done, 1);
    chk("fb_done_k", frame_done_k, 1);
    chk("fb_cnt", wr_cnt, N);
    chk("fb_cnt_k", wr_cnt_k, N);
    chk("fb_order", order_bad, 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fb_hits[%0d]", i), hits[i], 1);
      chk($sformatf("fb_hitsk[%0d]", i), hits_k[i], 1);
      chk($sformatf("fb_mem[%0d]", i), mem[i], ((i / W) % 2 == 1) ? 12'h000 : 12'h999);
      chk($sformatf("fb_memk[%0d]", i), mem_k[i], 12'h999);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_frame_loader.md
# gray_frame_loader

Upstream stage of the image pipeline. Accepts a raster-order RGB444 pixel stream and converts each pixel to a 12-bit replicated-luma grey value. Writes even rows into the source BRAM and writes zeros into odd rows, producing the decimated frame that `image_processor` interpolates. Signals frame completion so the processor (or SDK) can start.

## Interface
- DATA_WIDTH, 12, pixel width (RGB444 in, grey {Y,Y,Y} out)
- ADDR_WIDTH, 19, BRAM address width
- IMG_W, 400, pixels per row
- IMG_H, 300, rows per frame
- KEEP_ODD, 0, 1 = odd rows written with grey data instead of zero (bypass/debug)

Ports:
- clk_p  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_sof  in  1  first pixel of frame, qualified by s_valid
- s_data  in  12  {R[11:8],G[7:4],B[3:0]}
- hold  in  1  downstream busy; forces s_ready low
- bram_we  out  1  write strobe
- bram_addr  out  ADDR_WIDTH  write address
- bram_wdata  out  DATA_WIDTH  write data
- frame_done  out  1  level, full frame written
- sync_err  out  1  sticky, s_sof seen mid-frame

## Operation
- States: IDLE, STREAM, DONE. Reset -> IDLE.
- s_ready = !hold in all states.
- IDLE: accepted pixel with s_sof -> STREAM, processed as col 0/row 0; accepted pixel without s_sof dropped, no write.
- STREAM: each accepted pixel processed; col increments, wraps IMG_W-1 -> 0 with row+1; address increments by 1. Accepting pixel (IMG_W-1, IMG_H-1) -> DONE.
- STREAM with s_sof on an accepted pixel: sync_err <= 1, counters restart, that pixel treated as col 0/row 0; already-written data not cleared.
- DONE: frame_done = 1. Accepted pixel with s_sof -> STREAM, frame_done cleared the same edge; accepted non-sof pixels dropped.
- Luma: Y = (77R + 150G + 29B + 128) >> 8, 4-bit result (max 3968>>8 = 15, no overflow); 14-bit intermediate sum. Output word = {Y,Y,Y}.
- Odd rows (row[0]=1) with KEEP_ODD=0: bram_wdata = 0, bram_we still asserted.
- sync_err cleared only by rst.

## Timing
- Reset values: s_ready = !hold (combinational), bram_we 0, bram_addr 0, bram_wdata 0, frame_done 0, sync_err 0; counters 0.
- Two-stage pipeline: pixel accepted at edge N -> weighted sum registered at N+1 -> bram_we/addr/wdata registered, valid during cycle after N+2 edge (latency 2).
- Pipeline carries valid, address and odd-row flag with data; hold stalls only input acceptance, in-flight pixels still drain.
- frame_done rises one cycle after the last write's bram_we cycle (last pixel +3).
- Back-to-back accepts give one write per cycle; bubbles in s_valid give bubbles in bram_we, addresses stay contiguous.
- Mid-frame rst: pipeline flushed, no further writes, state IDLE.
- Last address written = IMG_W*IMG_H-1 = 119999.

## Structure
- Shared package img_pkg: IMG_W, IMG_H, DATA_LENGTH = IMG_W*IMG_H, luma coefficients 77/150/29, state enum type, shared with `image_processor`.
- One sub-module: `rgb444_to_gray`, the 2-stage luma pipeline with valid/sideband passthrough. Top holds FSM, counters, address generation.

## Test plan
- Reset mid-stream at pixel 500 -> no bram_we after reset; frame_done 0; next sof frame writes from address 0.
- Single pixel 0xFFF at sof -> bram_we at addr 0, wdata 0xFFF, two edges after accept; 0xF00 -> Y=(1155+128)>>8=5 -> 0x555; 0x000 -> 0x000.
- Full 400x300 frame, every pixel 0x888 -> addresses 0..119999 each written once; rows 0,2,… = 0x888, rows 1,3,… = 0x000; frame_done three cycles after last accept.
- Random s_valid gaps plus hold toggling every 7 cycles -> s_ready low whenever hold=1; write count still 120000, addresses contiguous.
- s_sof asserted again at pixel 1000 -> sync_err 1, next write at addr 0; pixels before first sof in IDLE produce no write.
- KEEP_ODD=1, frame of 0x0F0 -> every row written with Y=(2250+128)>>8=9 -> 0x999.
